// File: rtl/hart_bus_arbiter.sv
// Two-port (ibus/dbus) to single memory port arbiter with per-transaction timeout.
// Optional round-robin arbitration on collisions: define HART_ARB_RR_EN.
module hart_bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DBUS_PRIO = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ibus__req,
  input  logic [ADDR_W-1:0]   ibus__addr,
  output logic [DATA_W-1:0]   ibus__rdata,
  output logic                ibus__rdy,
  input  logic                dbus__req,
  input  logic [ADDR_W-1:0]   dbus__addr,
  input  logic [DATA_W/8-1:0] dbus__wmask,
  input  logic [DATA_W-1:0]   dbus__wdata,
  output logic [DATA_W-1:0]   dbus__rdata,
  output logic                dbus__rdy,
  output logic                mem__req,
  output logic [ADDR_W-1:0]   mem__addr,
  output logic [DATA_W/8-1:0] mem__wmask,
  output logic [DATA_W-1:0]   mem__wdata,
  input  logic                mem__ack,
  input  logic [DATA_W-1:0]   mem__rdata,
  output logic                err,
  output logic [7:0]          tmo_cnt
);

  localparam int MASK_W = DATA_W / 8;
  // Wait counter only needs to reach TIMEOUT-1; the final cycle is detected by compare.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [DATA_W-1:0]   ibus_rdata_q, ibus_rdata_d;
  logic                ibus_rdy_q, ibus_rdy_d;
  logic [DATA_W-1:0]   dbus_rdata_q, dbus_rdata_d;
  logic                dbus_rdy_q, dbus_rdy_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [MASK_W-1:0]   mem_wmask_q, mem_wmask_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                err_q, err_d;
  logic [7:0]          tmo_cnt_q, tmo_cnt_d;

  logic dbus_first;
  logic pick_d;
  logic pick_i;
  logic tmo_hit;

`ifdef HART_ARB_RR_EN
  logic last_gnt_q, last_gnt_d;  // 0 = ibus granted last, 1 = dbus

  assign dbus_first = ~last_gnt_q;
  assign last_gnt_d = (state_q == IDLE && (pick_d || pick_i)) ? pick_d : last_gnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_gnt_q <= 1'b0;
    else      last_gnt_q <= last_gnt_d;
  end
`else
  assign dbus_first = (DBUS_PRIO != 0);
`endif

  assign pick_d  = dbus__req && (!ibus__req || dbus_first);
  assign pick_i  = ibus__req && !pick_d;
  assign tmo_hit = (TIMEOUT != 0) && (wait_q == WAIT_LAST);

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    wait_d       = wait_q;
    ibus_rdata_d = ibus_rdata_q;
    ibus_rdy_d   = 1'b0;
    dbus_rdata_d = dbus_rdata_q;
    dbus_rdy_d   = 1'b0;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_wmask_d  = mem_wmask_q;
    mem_wdata_d  = mem_wdata_q;
    err_d        = err_q;
    tmo_cnt_d    = tmo_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d     = GNT_D;
          mem_req_d   = 1'b1;
          mem_addr_d  = dbus__addr;
          mem_wmask_d = dbus__wmask;
          mem_wdata_d = dbus__wdata;
          wait_d      = '0;
        end else if (pick_i) begin
          state_d     = GNT_I;
          mem_req_d   = 1'b1;
          mem_addr_d  = ibus__addr;
          mem_wmask_d = '0;
          mem_wdata_d = '0;
          wait_d      = '0;
        end
      end
      GNT_I, GNT_D: begin
        // Ack is checked before the timeout so a same-cycle ack always wins.
        if (mem__ack || tmo_hit) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (state_q == GNT_I) begin
            ibus_rdy_d   = 1'b1;
            ibus_rdata_d = mem__ack ? mem__rdata : '0;
          end else begin
            dbus_rdy_d   = 1'b1;
            dbus_rdata_d = mem__ack ? mem__rdata : '0;
          end
          if (!mem__ack) begin
            err_d = 1'b1;
            if (tmo_cnt_q != 8'hFF) tmo_cnt_d = tmo_cnt_q + 8'd1;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      ibus_rdata_q <= '0;
      ibus_rdy_q   <= 1'b0;
      dbus_rdata_q <= '0;
      dbus_rdy_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wmask_q  <= '0;
      mem_wdata_q  <= '0;
      err_q        <= 1'b0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      ibus_rdata_q <= ibus_rdata_d;
      ibus_rdy_q   <= ibus_rdy_d;
      dbus_rdata_q <= dbus_rdata_d;
      dbus_rdy_q   <= dbus_rdy_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wmask_q  <= mem_wmask_d;
      mem_wdata_q  <= mem_wdata_d;
      err_q        <= err_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign ibus__rdata = ibus_rdata_q;
  assign ibus__rdy   = ibus_rdy_q;
  assign dbus__rdata = dbus_rdata_q;
  assign dbus__rdy   = dbus_rdy_q;
  assign mem__req    = mem_req_q;
  assign mem__addr   = mem_addr_q;
  assign mem__wmask  = mem_wmask_q;
  assign mem__wdata  = mem_wdata_q;
  assign err         = err_q;
  assign tmo_cnt     = tmo_cnt_q;

endmodule

// File: tb/tb_hart_bus_arbiter.sv
// Directed bench for hart_bus_arbiter (TIMEOUT=4, DBUS_PRIO=1); expectations are hand-computed.
module tb_hart_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ibus__req;
  logic [31:0] ibus__addr;
  logic [31:0] ibus__rdata;
  logic        ibus__rdy;
  logic        dbus__req;
  logic [31:0] dbus__addr;
  logic [3:0]  dbus__wmask;
  logic [31:0] dbus__wdata;
  logic [31:0] dbus__rdata;
  logic        dbus__rdy;
  logic        mem__req;
  logic [31:0] mem__addr;
  logic [3:0]  mem__wmask;
  logic [31:0] mem__wdata;
  logic        mem__ack;
  logic [31:0] mem__rdata;
  logic        err;
  logic [7:0]  tmo_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  hart_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .DBUS_PRIO(1), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .ibus__req(ibus__req), .ibus__addr(ibus__addr),
    .ibus__rdata(ibus__rdata), .ibus__rdy(ibus__rdy),
    .dbus__req(dbus__req), .dbus__addr(dbus__addr), .dbus__wmask(dbus__wmask),
    .dbus__wdata(dbus__wdata), .dbus__rdata(dbus__rdata), .dbus__rdy(dbus__rdy),
    .mem__req(mem__req), .mem__addr(mem__addr), .mem__wmask(mem__wmask),
    .mem__wdata(mem__wdata), .mem__ack(mem__ack), .mem__rdata(mem__rdata),
    .err(err), .tmo_cnt(tmo_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; registered outputs of the new cycle are stable 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the cycle the request is presented; returns in the rdy cycle.
  task automatic serve(input string tag, input logic [31:0] addr, input logic [3:0] wmask,
                       input logic [31:0] wdata, input int waits, input logic [31:0] rd);
    step();
    for (int i = 0; i <= waits; i++) begin
      check({tag, " mem_req"},   32'(mem__req), 32'd1);
      check({tag, " mem_addr"},  mem__addr, addr);
      check({tag, " mem_wmask"}, 32'(mem__wmask), 32'(wmask));
      check({tag, " mem_wdata"}, mem__wdata, wdata);
      if (i == waits) begin
        mem__ack   = 1'b1;
        mem__rdata = rd;
      end
      step();
    end
    mem__ack   = 1'b0;
    mem__rdata = 32'hBAD0_BAD0;
    check({tag, " mem_req drop"}, 32'(mem__req), 32'd0);
  endtask

  task automatic check_rdy(input string tag, input logic irdy, input logic drdy,
                           input logic [31:0] ird, input logic [31:0] drd);
    check({tag, " ibus_rdy"},   32'(ibus__rdy), 32'(irdy));
    check({tag, " dbus_rdy"},   32'(dbus__rdy), 32'(drdy));
    check({tag, " ibus_rdata"}, ibus__rdata, ird);
    check({tag, " dbus_rdata"}, dbus__rdata, drd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    ibus__req = 1'b0; ibus__addr = '0;
    dbus__req = 1'b0; dbus__addr = '0; dbus__wmask = '0; dbus__wdata = '0;
    mem__ack = 1'b0; mem__rdata = '0;
    repeat (3) step();
    check("reset mem_req", 32'(mem__req), 32'd0);
    check("reset mem_addr", mem__addr, 32'd0);
    check_rdy("reset", 1'b0, 1'b0, 32'd0, 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset tmo_cnt", 32'(tmo_cnt), 32'd0);
    rst = 1'b1;
    step();

    // Collision straight after reset: dbus first either way; then dbus keeps requesting.
    ibus__req = 1'b1; ibus__addr = 32'h200;
    dbus__req = 1'b1; dbus__addr = 32'h3000; dbus__wmask = 4'h0; dbus__wdata = 32'h0;
    serve("col1", 32'h3000, 4'h0, 32'h0, 0, 32'h1111_1111);
    check_rdy("col1 rdy", 1'b0, 1'b1, 32'd0, 32'h1111_1111);
    step();
    check("col1 idle mem_req", 32'(mem__req), 32'd0);
    check("col1 idle dbus_rdy", 32'(dbus__rdy), 32'd0);
    dbus__addr = 32'h3004;
`ifdef HART_ARB_RR_EN
    serve("col2 rr", 32'h200, 4'h0, 32'h0, 0, 32'h2222_2222);
    check_rdy("col2 rr rdy", 1'b1, 1'b0, 32'h2222_2222, 32'h1111_1111);
    step();
    ibus__req = 1'b0;
    serve("col3 rr", 32'h3004, 4'h0, 32'h0, 0, 32'h3333_3333);
    check_rdy("col3 rr rdy", 1'b0, 1'b1, 32'h2222_2222, 32'h3333_3333);
    step();
    dbus__req = 1'b0;
`else
    serve("col2 fixed", 32'h3004, 4'h0, 32'h0, 0, 32'h3333_3333);
    check_rdy("col2 fixed rdy", 1'b0, 1'b1, 32'd0, 32'h3333_3333);
    step();
    dbus__req = 1'b0;
    serve("col3 fixed", 32'h200, 4'h0, 32'h0, 0, 32'h2222_2222);
    check_rdy("col3 fixed rdy", 1'b1, 1'b0, 32'h2222_2222, 32'h3333_3333);
    step();
    ibus__req = 1'b0;
`endif
    step();

    // Stray ack in IDLE: nothing happens.
    mem__ack = 1'b1; mem__rdata = 32'hFFFF_FFFF;
    step();
    mem__ack = 1'b0;
    check("stray mem_req", 32'(mem__req), 32'd0);
    check_rdy("stray", 1'b0, 1'b0, 32'h2222_2222, 32'h3333_3333);
    step();
    check_rdy("stray late", 1'b0, 1'b0, 32'h2222_2222, 32'h3333_3333);

    // Single ibus fetch, ack in cycle 1.
    ibus__req = 1'b1; ibus__addr = 32'h100;
    serve("fetch", 32'h100, 4'h0, 32'h0, 0, 32'h0000_0013);
    check_rdy("fetch rdy", 1'b1, 1'b0, 32'h0000_0013, 32'h3333_3333);
    step();
    ibus__req = 1'b0;
    check("fetch rdy pulse", 32'(ibus__rdy), 32'd0);

    // dbus byte write, 3 wait cycles: ack lands on the timeout cycle and must win.
    dbus__req = 1'b1; dbus__addr = 32'h2004; dbus__wmask = 4'h2; dbus__wdata = 32'h0000_AB00;
    serve("write", 32'h2004, 4'h2, 32'h0000_AB00, 3, 32'hDEAD_BEEF);
    check_rdy("write rdy", 1'b0, 1'b1, 32'h0000_0013, 32'hDEAD_BEEF);
    check("write err", 32'(err), 32'd0);
    check("write tmo_cnt", 32'(tmo_cnt), 32'd0);
    step();
    dbus__req = 1'b0; dbus__wmask = 4'h0; dbus__wdata = 32'h0;
    check("write rdy pulse", 32'(dbus__rdy), 32'd0);

    // Timeout: no ack, mem_req high for 4 cycles.
    ibus__req = 1'b1; ibus__addr = 32'h400;
    step();
    for (int i = 0; i < 4; i++) begin
      check("tmo mem_req high", 32'(mem__req), 32'd1);
      check("tmo ibus_rdy low", 32'(ibus__rdy), 32'd0);
      step();
    end
    check("tmo mem_req low", 32'(mem__req), 32'd0);
    check_rdy("tmo rdy", 1'b1, 1'b0, 32'd0, 32'hDEAD_BEEF);
    check("tmo err", 32'(err), 32'd1);
    check("tmo tmo_cnt", 32'(tmo_cnt), 32'd1);
    step();
    ibus__req = 1'b0;
    check("tmo rdy pulse", 32'(ibus__rdy), 32'd0);

    // A later acked transaction completes normally; err stays set.
    ibus__req = 1'b1; ibus__addr = 32'h104;
    serve("after tmo", 32'h104, 4'h0, 32'h0, 1, 32'hCAFE_F00D);
    check_rdy("after tmo rdy", 1'b1, 1'b0, 32'hCAFE_F00D, 32'hDEAD_BEEF);
    check("after tmo err", 32'(err), 32'd1);
    check("after tmo tmo_cnt", 32'(tmo_cnt), 32'd1);
    step();
    ibus__req = 1'b0;

    // Reset while in GNT_D.
    dbus__req = 1'b1; dbus__addr = 32'h5000; dbus__wmask = 4'hF; dbus__wdata = 32'h55;
    step();
    check("rstmid granted", 32'(mem__req), 32'd1);
    step();
    #2 rst = 1'b0;
    #1;
    check("rstmid mem_req", 32'(mem__req), 32'd0);
    check("rstmid err", 32'(err), 32'd0);
    check("rstmid tmo_cnt", 32'(tmo_cnt), 32'd0);
    check_rdy("rstmid", 1'b0, 1'b0, 32'd0, 32'd0);
    dbus__req = 1'b0; dbus__wmask = 4'h0; dbus__wdata = 32'h0;
    step();
    rst = 1'b1;
    step();
    check("rstmid no rdy", 32'(dbus__rdy), 32'd0);
    check("rstmid idle", 32'(mem__req), 32'd0);

    dbus__req = 1'b1; dbus__addr = 32'h6000;
    serve("fresh", 32'h6000, 4'h0, 32'h0, 0, 32'h0000_0066);
    check_rdy("fresh rdy", 1'b0, 1'b1, 32'd0, 32'h0000_0066);
    step();
    dbus__req = 1'b0;
    check("fresh rdy pulse", 32'(dbus__rdy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
